// File: rtl/instr_mem_loader_if.sv
// Bus bundle for instr_mem_loader: burst-load control, load-beat stream and fetch port.
// Load beats: a word transfers on a rising edge where ld_valid and ld_ready are both high.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 15
);
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              load_done;
  logic              busy;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;

  modport master (
    output load_start, load_base, load_len, ld_valid, ld_data, fetch_req, fetch_addr,
    input  ld_ready, load_done, busy, fetch_valid, fetch_data, fetch_err
  );

  modport slave (
    input  load_start, load_base, load_len, ld_valid, ld_data, fetch_req, fetch_addr,
    output ld_ready, load_done, busy, fetch_valid, fetch_data, fetch_err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with a burst loader (write side) and a registered fetch port (read side).
// Fetches are only served in IDLE; during a load they are rejected with a one-cycle fetch_err.
module instr_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_mem_loader_if.slave    bus,
  output logic                 state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic                load_done_q, load_done_d;
  logic                beat;
  logic                mem_we;
  logic                fetch_ok;
  logic                fetch_rej;
  logic                fetch_valid_q;
  logic                fetch_err_q;
  logic [DATA_W-1:0]   fetch_data_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign beat      = (state_q == S_LOAD) && bus.ld_valid;
  assign fetch_ok  = bus.fetch_req && (state_q == S_IDLE);
  assign fetch_rej = bus.fetch_req && (state_q == S_LOAD);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    load_done_d = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          // A zero-length request completes immediately without entering LOAD.
          if (bus.load_len != '0) begin
            state_d     = S_LOAD;
            wr_ptr_d    = bus.load_base;
            remaining_d = bus.load_len;
          end else begin
            load_done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (beat) begin
          mem_we      = 1'b1;
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (remaining_q == (ADDR_W+1)'(1)) begin
            state_d     = S_IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      load_done_q <= load_done_d;
    end
  end

  // Storage is deliberately left out of reset so an aborted load keeps earlier contents.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[wr_ptr_q] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      fetch_valid_q <= fetch_ok;
      fetch_err_q   <= fetch_rej;
      if (fetch_ok) begin
        fetch_data_q <= mem[bus.fetch_addr];
      end
    end
  end

  assign bus.ld_ready    = (state_q == S_LOAD);
  assign bus.busy        = (state_q == S_LOAD);
  assign bus.load_done   = load_done_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.fetch_data  = fetch_data_q;
  assign state_dbg       = state_q;

  a_fetch_excl: assert property (@(posedge clk) disable iff (rst)
    !(fetch_valid_q && fetch_err_q));
  a_load_nonzero: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_LOAD) |-> (remaining_q != '0));

endmodule
